// File: rtl/vc_test_pkg.sv
// Shared constants and helpers for the vc_test responder components.
package vc_test_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois right-shift tap mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vc_test_lfsr16.sv
// 16-bit Galois LFSR that steps only when en_i is high.
module vc_test_lfsr16
    import vc_test_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/vc_test_rand_delay_tag_responder.sv
// Tag-indexed echo responder: one slot per tag, pseudo-random release delay,
// round-robin selection among slots whose delay has expired.
module vc_test_rand_delay_tag_responder
    import vc_test_pkg::*;
#(
    parameter int p_msg_nbits  = 10,
    parameter int p_tag_nbits  = 2,
    parameter int p_tag_offset = 8,
    parameter int p_max_delay  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic [p_tag_nbits:0]   pending
);

    localparam int MW     = p_msg_nbits;
    localparam int TW     = p_tag_nbits;
    localparam int NSLOTS = 1 << TW;
    localparam int DW     = width_for(p_max_delay + 1);

    logic [NSLOTS-1:0] occ_q;
    logic [NSLOTS-1:0] occ_d;
    logic [MW-1:0]     msg_q [NSLOTS];
    logic [MW-1:0]     msg_d [NSLOTS];
    logic [DW-1:0]     dly_q [NSLOTS];
    logic [DW-1:0]     dly_d [NSLOTS];
    logic [TW-1:0]     ptr_q;
    logic [TW-1:0]     ptr_d;

    logic [NSLOTS-1:0] eligible;
    logic [NSLOTS-1:0] load;
    logic [NSLOTS-1:0] clr;
    logic [TW-1:0]     in_tag;
    logic [TW-1:0]     grant_idx;
    logic [TW-1:0]     cand;
    logic              grant_found;
    logic              accept;
    logic              fire;
    logic [15:0]       lfsr_state;
    logic [DW-1:0]     new_dly;

    assign in_tag  = in_msg[p_tag_offset +: TW];
    assign in_rdy  = reset && !occ_q[in_tag];
    assign accept  = in_val && in_rdy;
    assign new_dly = DW'(lfsr_state % 16'(p_max_delay + 1));

    vc_test_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (reset),
        .en_i    (accept),
        .state_o (lfsr_state)
    );

    // Search begins at ptr so the slot after the last winner has priority.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < NSLOTS; k++) begin
            cand = ptr_q + TW'(k);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign out_val = grant_found;
    assign out_msg = grant_found ? msg_q[grant_idx] : '0;
    assign fire    = out_val && out_rdy;
    assign ptr_d   = fire ? (grant_idx + TW'(1)) : ptr_q;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOTS; gi++) begin : g_slot
            assign load[gi]     = accept && (in_tag == TW'(gi));
            assign clr[gi]      = fire && (grant_idx == TW'(gi));
            assign eligible[gi] = occ_q[gi] && (dly_q[gi] == '0);
            assign occ_d[gi]    = load[gi] || (occ_q[gi] && !clr[gi]);
            assign msg_d[gi]    = load[gi] ? in_msg : msg_q[gi];
            assign dly_d[gi]    = load[gi] ? new_dly :
                                  ((occ_q[gi] && (dly_q[gi] != '0)) ? (dly_q[gi] - DW'(1))
                                                                    : dly_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
            ptr_q <= '0;
            for (int k = 0; k < NSLOTS; k++) begin
                msg_q[k] <= '0;
                dly_q[k] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            ptr_q <= ptr_d;
            for (int k = 0; k < NSLOTS; k++) begin
                msg_q[k] <= msg_d[k];
                dly_q[k] <= dly_d[k];
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < NSLOTS; k++) begin
            pending = pending + (TW+1)'(occ_q[k]);
        end
    end

endmodule

// File: tb/tb_vc_test_rand_delay_tag_responder.sv
// Bench: directed vector table on a zero-delay instance, scoreboard on a
// random-delay instance, plus a mid-operation reset sequence.
module tb_vc_test_rand_delay_tag_responder;

    localparam int MW     = 10;
    localparam int TW     = 2;
    localparam int NSLOTS = 4;
    localparam int MAXD   = 2;

    logic          clk;
    logic          reset;
    logic          in_val;
    logic [MW-1:0] in_msg;
    logic          out_rdy;

    logic          d0_in_rdy, d0_out_val;
    logic [MW-1:0] d0_out_msg;
    logic [TW:0]   d0_pending;
    logic          d2_in_rdy, d2_out_val;
    logic [MW-1:0] d2_out_msg;
    logic [TW:0]   d2_pending;

    int pass_cnt = 0;
    int total_cnt = 0;

    vc_test_rand_delay_tag_responder #(
        .p_msg_nbits(MW), .p_tag_nbits(TW), .p_tag_offset(8), .p_max_delay(0)
    ) dut0 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(d0_in_rdy),
        .in_msg(in_msg), .out_val(d0_out_val), .out_rdy(out_rdy),
        .out_msg(d0_out_msg), .pending(d0_pending)
    );

    vc_test_rand_delay_tag_responder #(
        .p_msg_nbits(MW), .p_tag_nbits(TW), .p_tag_offset(8), .p_max_delay(MAXD)
    ) dut2 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(d2_in_rdy),
        .in_msg(in_msg), .out_val(d2_out_val), .out_rdy(out_rdy),
        .out_msg(d2_out_msg), .pending(d2_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          val;
        logic [9:0]  msg;
        bit          ordy;
        bit          e_in_rdy;
        bit          e_out_val;
        logic [9:0]  e_out_msg;
        logic [2:0]  e_pending;
    } vec_t;

    typedef struct {
        logic [9:0] msg;
        int         acc_cyc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    function automatic vec_t mk(bit r, bit v, logic [9:0] m, bit o,
                                bit er, bit eo, logic [9:0] em, logic [2:0] ep);
        vec_t x;
        x.rst_n = r; x.val = v; x.msg = m; x.ordy = o;
        x.e_in_rdy = er; x.e_out_val = eo; x.e_out_msg = em; x.e_pending = ep;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic bit tag_busy(input logic [1:0] t);
        foreach (sb[j]) if (sb[j].msg[9:8] == t) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [9:0] rmsgs [8];
        int idx;
        int cyc;
        int found;
        bit exp_rdy;

        reset = 1'b0; in_val = 1'b0; in_msg = '0; out_rdy = 1'b0;

        // rst, val, msg, ordy  ->  in_rdy, out_val, out_msg, pending
        vecs.push_back(mk(0,1,10'h0aa,1, 0,0,10'h000,0));   // 0 reset held
        vecs.push_back(mk(0,1,10'h0aa,1, 0,0,10'h000,0));   // 1
        vecs.push_back(mk(1,1,10'h0aa,1, 1,0,10'h000,0));   // 2 accept 0aa
        vecs.push_back(mk(1,1,10'h1bb,1, 1,1,10'h0aa,1));   // 3 accept+fire
        vecs.push_back(mk(1,0,10'h000,1, 1,1,10'h1bb,1));   // 4
        vecs.push_back(mk(1,0,10'h000,1, 1,0,10'h000,0));   // 5 empty
        vecs.push_back(mk(1,1,10'h0aa,0, 1,0,10'h000,0));   // 6 collision test
        vecs.push_back(mk(1,1,10'h0ee,0, 0,1,10'h0aa,1));   // 7 tag 0 busy
        vecs.push_back(mk(1,1,10'h1bb,0, 1,1,10'h0aa,1));   // 8
        vecs.push_back(mk(1,1,10'h0ee,1, 0,1,10'h0aa,2));   // 9 fire 0aa
        vecs.push_back(mk(1,1,10'h0ee,0, 1,1,10'h1bb,1));   // 10 accept 0ee
        vecs.push_back(mk(1,0,10'h000,1, 0,1,10'h1bb,2));   // 11
        vecs.push_back(mk(1,0,10'h000,1, 0,1,10'h0ee,1));   // 12
        vecs.push_back(mk(1,0,10'h000,1, 1,0,10'h000,0));   // 13
        vecs.push_back(mk(0,0,10'h000,0, 0,0,10'h000,0));   // 14 reset, ptr->0
        vecs.push_back(mk(1,1,10'h0aa,0, 1,0,10'h000,0));   // 15 fill
        vecs.push_back(mk(1,1,10'h1bb,0, 1,1,10'h0aa,1));   // 16
        vecs.push_back(mk(1,1,10'h2cc,0, 1,1,10'h0aa,2));   // 17
        vecs.push_back(mk(1,1,10'h3dd,0, 1,1,10'h0aa,3));   // 18
        vecs.push_back(mk(1,1,10'h0ee,0, 0,1,10'h0aa,4));   // 19 full, stalled
        vecs.push_back(mk(1,1,10'h1ff,0, 0,1,10'h0aa,4));   // 20
        vecs.push_back(mk(1,1,10'h2ab,0, 0,1,10'h0aa,4));   // 21
        vecs.push_back(mk(1,1,10'h3cd,0, 0,1,10'h0aa,4));   // 22
        vecs.push_back(mk(1,1,10'h0aa,0, 0,1,10'h0aa,4));   // 23
        vecs.push_back(mk(1,0,10'h000,1, 0,1,10'h0aa,4));   // 24 drain in order
        vecs.push_back(mk(1,0,10'h000,1, 1,1,10'h1bb,3));   // 25
        vecs.push_back(mk(1,0,10'h000,1, 1,1,10'h2cc,2));   // 26
        vecs.push_back(mk(1,0,10'h000,1, 1,1,10'h3dd,1));   // 27 ptr wraps
        vecs.push_back(mk(1,0,10'h000,1, 1,0,10'h000,0));   // 28
        vecs.push_back(mk(1,1,10'h0aa,0, 1,0,10'h000,0));   // 29 mid-op reset
        vecs.push_back(mk(1,1,10'h1bb,0, 1,1,10'h0aa,1));   // 30
        vecs.push_back(mk(1,1,10'h2cc,0, 1,1,10'h0aa,2));   // 31
        vecs.push_back(mk(0,1,10'h3dd,1, 0,0,10'h000,0));   // 32 reset pulse
        vecs.push_back(mk(1,0,10'h000,1, 1,0,10'h000,0));   // 33

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            reset = vecs[i].rst_n; in_val = vecs[i].val;
            in_msg = vecs[i].msg; out_rdy = vecs[i].ordy;
            #3;
            $display("row %0d: rst_n=%0b val=%0b msg=%h ordy=%0b -> in_rdy=%0b out_val=%0b out_msg=%h pending=%0d",
                     i, reset, in_val, in_msg, out_rdy, d0_in_rdy, d0_out_val, d0_out_msg, d0_pending);
            chk($sformatf("row%0d_in_rdy", i), 32'(d0_in_rdy), 32'(vecs[i].e_in_rdy));
            chk($sformatf("row%0d_out_val", i), 32'(d0_out_val), 32'(vecs[i].e_out_val));
            chk($sformatf("row%0d_out_msg", i), 32'(d0_out_msg), 32'(vecs[i].e_out_msg));
            chk($sformatf("row%0d_pending", i), 32'(d0_pending), 32'(vecs[i].e_pending));
        end

        // No stale message may surface after the reset pulse.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_val = 1'b0; in_msg = '0; out_rdy = 1'b1;
            #3;
            $display("post-reset cycle %0d: d0 out_val=%0b d2 out_val=%0b", c, d0_out_val, d2_out_val);
            chk("stale_d0_out_val", 32'(d0_out_val), 32'd0);
            chk("stale_d2_out_val", 32'(d2_out_val), 32'd0);
            chk("stale_d2_pending", 32'(d2_pending), 32'd0);
        end

        // Random-delay stream on the p_max_delay=2 instance.
        rmsgs[0] = 10'h0aa; rmsgs[1] = 10'h1bb; rmsgs[2] = 10'h2cc; rmsgs[3] = 10'h3dd;
        rmsgs[4] = 10'h0ee; rmsgs[5] = 10'h1ff; rmsgs[6] = 10'h2ab; rmsgs[7] = 10'h3cd;
        idx = 0;
        cyc = 0;
        while (cyc < 200 && (idx < 8 || sb.size() > 0)) begin
            @(posedge clk); #1;
            in_val = (idx < 8);
            in_msg = (idx < 8) ? rmsgs[idx] : 10'h000;
            out_rdy = 1'b1;
            #3;
            chk("rand_pending", 32'(d2_pending), 32'(sb.size()));
            if (in_val) begin
                exp_rdy = !tag_busy(in_msg[9:8]);
                chk("rand_in_rdy", 32'(d2_in_rdy), 32'(exp_rdy));
            end
            if (d2_out_val) begin
                found = -1;
                foreach (sb[j]) if (found < 0 && sb[j].msg[9:8] == d2_out_msg[9:8]) found = j;
                if (found < 0) begin
                    chk("rand_unexpected_out", 32'(d2_out_msg), 32'hFFFF_FFFF);
                end else begin
                    $display("rand cycle %0d: out %h latency %0d", cyc, d2_out_msg, cyc - sb[found].acc_cyc);
                    chk("rand_out_msg", 32'(d2_out_msg), 32'(sb[found].msg));
                    chk("rand_latency_ok",
                        32'((cyc - sb[found].acc_cyc >= 1) && (cyc - sb[found].acc_cyc <= 1 + MAXD + NSLOTS - 1)),
                        32'd1);
                    sb.delete(found);
                end
            end
            if (in_val && d2_in_rdy) begin
                $display("rand cycle %0d: accept %h", cyc, in_msg);
                sb.push_back('{msg: in_msg, acc_cyc: cyc});
                idx++;
            end
            cyc++;
        end
        chk("rand_all_sent", 32'(idx), 32'd8);
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        in_val = 1'b0;
        #3;
        chk("rand_drained_out_val", 32'(d2_out_val), 32'd0);
        chk("rand_drained_pending", 32'(d2_pending), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
